alu_disp_scan: RTL and testbench

ALU_DISP_SCAN -- requirements
Module: alu_disp_scan

---
 rtl/alu_disp_scan.sv | 176 +++++++++++++++++
 tb/tb_alu_disp_scan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_disp_scan.sv
// Two-digit multiplexed 7-segment scanner for an ALU result, with blanking and error glyphs.
// Optional error blinking is compiled in with the DISP_BLINK_EN macro.
module alu_disp_scan #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter int unsigned BLINK_DIV   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] dec_bin,
    input  logic [3:0] unis_bin,
    input  logic       zero,
    input  logic       error,
    output logic [6:0] seg,
    output logic [1:0] digit_sel,
    output logic       zero_led,
    output logic       err_led,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        UNITS = 2'd1,
        TENS  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] refresh_q, refresh_d;
    logic [3:0]  dec_q, dec_d;
    logic [3:0]  unis_q, unis_d;
    logic        zero_q, zero_d;
    logic        error_q, error_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  digit_sel_q, digit_sel_d;
    logic        zero_led_q, zero_led_d;
    logic        err_led_q, err_led_d;
    logic        refresh_tc;
    logic        blink_vis;

    function automatic logic [6:0] encode_digit(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign refresh_tc = (refresh_q == 16'(REFRESH_DIV - 1));

`ifdef DISP_BLINK_EN
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    // The blink counter ticks once per full scan period, at the TENS->UNITS handover.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (state_q == TENS && refresh_tc) begin
            if (blink_cnt_q == 8'(BLINK_DIV - 1)) begin
                blink_cnt_d = 8'd0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= 8'd0;
            blink_ph_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blink_vis = blink_ph_q;
`else
    assign blink_vis = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        refresh_d = refresh_q;
        dec_d     = dec_q;
        unis_d    = unis_q;
        zero_d    = zero_q;
        error_d   = error_q;
        if (load) begin
            dec_d   = dec_bin;
            unis_d  = unis_bin;
            zero_d  = zero;
            error_d = error;
        end
        case (state_q)
            UNITS, TENS: begin
                if (refresh_tc) begin
                    refresh_d = 16'd0;
                    state_d   = (state_q == UNITS) ? TENS : UNITS;
                end else begin
                    refresh_d = refresh_q + 16'd1;
                end
            end
            default: begin
                if (load) begin
                    state_d   = UNITS;
                    refresh_d = 16'd0;
                end
            end
        endcase
    end

    // Output registers follow the current state and holding registers, so they lag them by one clock.
    always_comb begin
        seg_d       = 7'h00;
        digit_sel_d = 2'b00;
        zero_led_d  = 1'b0;
        err_led_d   = 1'b0;
        if (state_q == UNITS || state_q == TENS) begin
            zero_led_d  = zero_q;
            err_led_d   = error_q & blink_vis;
            digit_sel_d = (state_q == UNITS) ? 2'b01 : 2'b10;
            if (error_q) begin
                seg_d = blink_vis ? ((state_q == UNITS) ? 7'h50 : 7'h79) : 7'h00;
            end else if (state_q == UNITS) begin
                seg_d = encode_digit(unis_q);
            end else begin
                seg_d = (dec_q == 4'd0) ? 7'h00 : encode_digit(dec_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            refresh_q   <= 16'd0;
            dec_q       <= 4'd0;
            unis_q      <= 4'd0;
            zero_q      <= 1'b0;
            error_q     <= 1'b0;
            seg_q       <= 7'h00;
            digit_sel_q <= 2'b00;
            zero_led_q  <= 1'b0;
            err_led_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            refresh_q   <= refresh_d;
            dec_q       <= dec_d;
            unis_q      <= unis_d;
            zero_q      <= zero_d;
            error_q     <= error_d;
            seg_q       <= seg_d;
            digit_sel_q <= digit_sel_d;
            zero_led_q  <= zero_led_d;
            err_led_q   <= err_led_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = digit_sel_q;
    assign zero_led  = zero_led_q;
    assign err_led   = err_led_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_disp_scan.sv
// Bench for alu_disp_scan: scan-time reference model plus directed literal checks and random traffic.
module tb_alu_disp_scan;

    localparam int RD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] dec_bin = 4'd0;
    logic [3:0] unis_bin = 4'd0;
    logic       zero = 1'b0;
    logic       error = 1'b0;
    logic [6:0] seg;
    logic [1:0] digit_sel;
    logic       zero_led;
    logic       err_led;
    logic [1:0] dbg_state;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alu_disp_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .load(load), .dec_bin(dec_bin), .unis_bin(unis_bin),
        .zero(zero), .error(error), .seg(seg), .digit_sel(digit_sel),
        .zero_led(zero_led), .err_led(err_led), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: the scan is a pure function of cycles elapsed since the first load.
    logic [6:0] glyph [16];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [3:0] m_dec = 4'd0, m_unis = 4'd0;
    logic       m_zero = 1'b0, m_err = 1'b0;
    logic [6:0] exp_seg = 7'h00;
    logic [1:0] exp_sel = 2'b00;
    logic       exp_zl = 1'b0, exp_el = 1'b0;

    initial begin
        glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
        glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
        glyph[8] = 7'h7F; glyph[9] = 7'h6F;
        for (int i = 10; i < 16; i++) glyph[i] = 7'h40;
    end

    always @(posedge clk) begin
        bit in_units;
        bit vis;
        if (rst) begin
            m_active = 1'b0; m_t = 0;
            m_dec = 4'd0; m_unis = 4'd0; m_zero = 1'b0; m_err = 1'b0;
            exp_seg = 7'h00; exp_sel = 2'b00; exp_zl = 1'b0; exp_el = 1'b0;
        end else begin
            if (!m_active) begin
                exp_seg = 7'h00; exp_sel = 2'b00; exp_zl = 1'b0; exp_el = 1'b0;
            end else begin
                in_units = ((m_t / RD) % 2) == 0;
`ifdef DISP_BLINK_EN
                vis = ((m_t / (2 * RD * BD)) % 2) == 0;
`else
                vis = 1'b1;
`endif
                exp_sel = in_units ? 2'b01 : 2'b10;
                exp_zl  = m_zero;
                exp_el  = m_err && vis;
                if (m_err) exp_seg = !vis ? 7'h00 : (in_units ? 7'h50 : 7'h79);
                else if (in_units) exp_seg = glyph[m_unis];
                else exp_seg = (m_dec == 4'd0) ? 7'h00 : glyph[m_dec];
            end
            if (load) begin
                m_dec = dec_bin; m_unis = unis_bin; m_zero = zero; m_err = error;
            end
            if (m_active) m_t++;
            else if (load) begin
                m_active = 1'b1; m_t = 0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", {1'b0, seg}, {1'b0, exp_seg});
            check("model_sel", {6'd0, digit_sel}, {6'd0, exp_sel});
            check("model_zled", {7'd0, zero_led}, {7'd0, exp_zl});
            check("model_eled", {7'd0, err_led}, {7'd0, exp_el});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] d, input logic [3:0] u, input logic z, input logic e);
        dec_bin = d; unis_bin = u; zero = z; error = e; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input logic [6:0] s, input logic [1:0] d,
                       input logic zl, input logic el);
        check({name, "_seg"}, {1'b0, seg}, {1'b0, s});
        check({name, "_sel"}, {6'd0, digit_sel}, {6'd0, d});
        check({name, "_zled"}, {7'd0, zero_led}, {7'd0, zl});
        check({name, "_eled"}, {7'd0, err_led}, {7'd0, el});
    endtask

    initial begin
        cyc(1);
        chk_en = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            lit("idle", 7'h00, 2'b00, 1'b0, 1'b0);
            cyc(1);
        end

        // Load 4/2, then reload 1/2 while TENS sits at refresh count 2.
        do_load(4'd4, 4'd2, 1'b0, 1'b0);
        lit("load_edge", 7'h00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1); lit("units_2", 7'h5B, 2'b01, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1); lit("tens_4", 7'h66, 2'b10, 1'b0, 1'b0);
        end
        do_load(4'd1, 4'd2, 1'b0, 1'b0);
        lit("tens_old", 7'h66, 2'b10, 1'b0, 1'b0);
        cyc(1); lit("tens_1", 7'h06, 2'b10, 1'b0, 1'b0);
        cyc(1); lit("units_after", 7'h5B, 2'b01, 1'b0, 1'b0);

        // Zero result with leading-zero blanking.
        do_reset();
        do_load(4'd0, 4'd0, 1'b1, 1'b0);
        cyc(1); lit("zero_units", 7'h3F, 2'b01, 1'b1, 1'b0);
        cyc(4); lit("zero_tens", 7'h00, 2'b10, 1'b1, 1'b0);

        // Error glyphs, and blink window when enabled.
        do_reset();
        do_load(4'd15, 4'd15, 1'b0, 1'b1);
        cyc(1); lit("err_units", 7'h50, 2'b01, 1'b0, 1'b1);
        cyc(4); lit("err_tens", 7'h79, 2'b10, 1'b0, 1'b1);
        cyc(12);
`ifdef DISP_BLINK_EN
        lit("err_blank", 7'h00, 2'b01, 1'b0, 1'b0);
`else
        lit("err_steady", 7'h50, 2'b01, 1'b0, 1'b1);
`endif

        // Reset at UNITS refresh count 1 with a simultaneous load.
        do_reset();
        do_load(4'd7, 4'd8, 1'b1, 1'b0);
        cyc(1);
        rst = 1'b1; load = 1'b1; dec_bin = 4'd9; unis_bin = 4'd9; zero = 1'b1;
        cyc(1);
        rst = 1'b0; load = 1'b0;
        lit("rst_load", 7'h00, 2'b00, 1'b0, 1'b0);
        cyc(3); lit("rst_stays", 7'h00, 2'b00, 1'b0, 1'b0);

        // Random traffic: sparse loads, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            load     = ($urandom_range(0, 39) == 0);
            dec_bin  = 4'($urandom_range(0, 15));
            unis_bin = 4'($urandom_range(0, 15));
            zero     = 1'($urandom_range(0, 1));
            error    = 1'($urandom_range(0, 1));
            cyc(1);
        end
        rst = 1'b0; load = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
